qif_neuron_scheduler: RTL and testbench
=======================================

# qif_neuron_scheduler

Time-multiplexed controller that shares one 8-bit signed QIF membrane-update datapath among N_NEURONS virtual neurons. It holds per-neuron membrane potential and synaptic current in register files. On each timestep it walks the neurons in index order, applies the QIF update or threshold reset, and emits one spike event per firing neuron over a ready/valid handshake. It sits between the synaptic-input logic, which writes currents, and the spike router, which consumes events.

## Interface
- N_NEURONS, 8: number of virtual neurons, 2..256.
- AW, $clog2(N_NEURONS): neuron index width.
- V_RESET, -8'sd20: reset and post-spike membrane potential.
- V_TH, 8'sd50: firing threshold; fire when V >= V_TH.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- step_start  in  1  single-cycle request to run one timestep; honoured only in IDLE.
- busy  out  1  high from the cycle after an accepted step_start until step_done.
- step_done  out  1  one-cycle pulse when the last neuron is committed.
- syn_we  in  1  synaptic-current write enable.
- syn_addr  in  AW  neuron index for the write.
- syn_data  in  8  signed I_syn value; persists until overwritten.
- spike_valid  out  1  spike event pending.
- spike_id  out  AW  index of the firing neuron; stable while spike_valid=1.
- spike_ready  in  1  consumer accepts the event when spike_valid && spike_ready.
- v_rd_addr  in  AW  membrane readback index.
- v_rd_data  out  8  signed V[v_rd_addr], registered, 1-cycle latency.

## Operation
- FSM states: IDLE, FETCH, CALC, COMMIT, SPIKE, DONE.
- IDLE: step_start=1 -> FETCH with k=0. Otherwise stay in IDLE.
- FETCH: latch V[k] and I[k] into operand registers -> CALC.
- CALC: fire = (V >= V_TH). If fire, Vn = V_RESET. Otherwise Vn = sat8(V + q*q + I/4), where:
  - q = V/8, signed, truncated toward zero (-20/8 = -2).
  - I/4 is signed, truncated toward zero.
  - The sum is computed at 10 bits, then clamped to [-128, 127].
  - Register Vn and fire -> COMMIT.
- COMMIT: write Vn to V[k]. If fire, load spike_id=k and set spike_valid -> SPIKE. Otherwise go to FETCH with k+1, or to DONE if k = N_NEURONS-1.
- SPIKE: hold spike_valid and spike_id until spike_ready=1. On acceptance, clear spike_valid the next cycle and go to FETCH with k+1, or to DONE if k = N_NEURONS-1.
- DONE: step_done=1 for one cycle -> IDLE.
- step_start when not in IDLE is ignored, not queued.
- syn writes are accepted in every state.
  - A write to index k in the same cycle FETCH reads I[k] does not affect the value used; FETCH uses the old value and the new value applies from the next timestep.
  - A write to an index not yet fetched in the current step is used in this step.
- Membrane state is not externally writable; only reset and the FSM modify it.

## Timing
- Reset values:
  - All V[i] = V_RESET and all I[i] = 0.
  - FSM in IDLE, k=0.
  - busy=0, step_done=0, spike_valid=0, spike_id=0, v_rd_data=V_RESET.
- Reset asserted mid-step aborts the step immediately. No step_done is issued and a pending spike is dropped.
- Without spikes:
  - Each neuron takes 3 cycles (FETCH, CALC, COMMIT).
  - step_done rises 3*N_NEURONS+1 cycles after the edge that samples step_start.
  - busy falls on the same edge as step_done.
- Each spike adds 1 cycle plus the number of cycles spike_ready is held low.
- spike_valid may be asserted with spike_ready already high; acceptance then takes exactly 1 cycle in SPIKE.
- v_rd_data reflects a COMMIT write on the cycle after the write edge when v_rd_addr=k.

## Test plan
- Reset release: read v_rd_data for all indices -> each reads -20. busy=0, spike_valid=0, step_done=0.
- All I=0, one step -> every V goes -20 -> -16. step_done pulses 25 cycles after step_start (N=8). No spikes.
- I[3]=127, all other I=0, four steps:
  - Neuron 3 goes -20 -> 15 -> 47 -> 103.
  - In step 4 it fires: spike_id=3, V[3]=-20.
  - The other neurons follow the I=0 trajectory.
- Backpressure: with the step-4 spike pending, hold spike_ready=0 for 10 cycles.
  - The FSM stalls in SPIKE with spike_id=3 and spike_valid steady.
  - step_done is delayed by exactly 11 cycles versus the no-spike step.
- Collision:
  - Write syn_addr=0, syn_data=127 in the cycle step_start is sampled -> neuron 0 uses old I=0 this step and 127 next step.
  - A second step_start while busy produces only one step_done.
- Mid-step reset: assert rst_n=0 while in CALC for k=4.
  - All V return to -20 and busy drops asynchronously.
  - The next step from IDLE behaves as after power-on.

Source files
------------

// File: rtl/qif_neuron_scheduler.sv
// Time-multiplexed QIF neuron scheduler: one 8-bit membrane datapath shared by N_NEURONS neurons.
// Per neuron FETCH/CALC/COMMIT (3 cycles); firing neurons stall in SPIKE until the event is accepted.
module qif_neuron_scheduler #(
    parameter int                 N_NEURONS = 8,
    parameter int                 AW        = $clog2(N_NEURONS),
    parameter logic signed [7:0]  V_RESET   = -8'sd20,
    parameter logic signed [7:0]  V_TH      = 8'sd50
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step_start,
    output logic                 busy,
    output logic                 step_done,
    input  logic                 syn_we,
    input  logic [AW-1:0]        syn_addr,
    input  logic signed [7:0]    syn_data,
    output logic                 spike_valid,
    output logic [AW-1:0]        spike_id,
    input  logic                 spike_ready,
    input  logic [AW-1:0]        v_rd_addr,
    output logic signed [7:0]    v_rd_data
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CALC, S_COMMIT, S_SPIKE, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [AW-1:0]       r_k, w_k_nxt;
    logic                w_enter_fetch;
    logic                w_last;
    logic signed [7:0]   r_v [N_NEURONS];
    logic signed [7:0]   r_i [N_NEURONS];
    logic signed [7:0]   r_v_op, r_i_op, r_vn, r_v_rd;
    logic                r_fire, r_spike_vld, r_step_done;
    logic [AW-1:0]       r_spike_id;

    logic signed [7:0]   w_q, w_i4, w_sat;
    logic signed [9:0]   w_v10, w_q10, w_i10, w_sq, w_sum;
    logic                w_fire;

    assign w_last      = (r_k == AW'(N_NEURONS - 1));
    assign busy        = (r_state != S_IDLE);
    assign step_done   = r_step_done;
    assign spike_valid = r_spike_vld;
    assign spike_id    = r_spike_id;
    assign v_rd_data   = r_v_rd;

    // Operands are captured on the edge that enters FETCH, so a syn write landing on
    // that same edge is only seen by the next timestep.
    always_comb begin
        w_state_nxt   = r_state;
        w_k_nxt       = r_k;
        w_enter_fetch = 1'b0;
        case (r_state)
            S_IDLE: if (step_start) begin
                w_state_nxt   = S_FETCH;
                w_k_nxt       = '0;
                w_enter_fetch = 1'b1;
            end
            S_FETCH:  w_state_nxt = S_CALC;
            S_CALC:   w_state_nxt = S_COMMIT;
            S_COMMIT, S_SPIKE: begin
                if ((r_state == S_COMMIT && !r_fire) || (r_state == S_SPIKE && spike_ready)) begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt   = S_FETCH;
                        w_k_nxt       = r_k + AW'(1);
                        w_enter_fetch = 1'b1;
                    end
                end else if (r_state == S_COMMIT) begin
                    w_state_nxt = S_SPIKE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_k_nxt     = '0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end

    // Signed divides truncate toward zero; the 10-bit sum cannot overflow before clamping.
    assign w_q    = r_v_op / 8'sd8;
    assign w_i4   = r_i_op / 8'sd4;
    assign w_v10  = r_v_op;
    assign w_q10  = w_q;
    assign w_i10  = w_i4;
    assign w_sq   = w_q10 * w_q10;
    assign w_sum  = w_v10 + w_sq + w_i10;
    assign w_fire = (r_v_op >= V_TH);

    always_comb begin
        w_sat = w_sum[7:0];
        if (w_sum > 10'sd127)
            w_sat = 8'sd127;
        else if (w_sum < -10'sd128)
            w_sat = -8'sd128;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < N_NEURONS; n++) begin
                r_v[n] <= V_RESET;
                r_i[n] <= '0;
            end
            r_v_op      <= '0;
            r_i_op      <= '0;
            r_vn        <= '0;
            r_fire      <= 1'b0;
            r_spike_vld <= 1'b0;
            r_spike_id  <= '0;
            r_step_done <= 1'b0;
            r_v_rd      <= V_RESET;
        end else begin
            if (syn_we)
                r_i[syn_addr] <= syn_data;
            if (w_enter_fetch) begin
                r_v_op <= r_v[w_k_nxt];
                r_i_op <= r_i[w_k_nxt];
            end
            if (r_state == S_CALC) begin
                r_fire <= w_fire;
                r_vn   <= w_fire ? V_RESET : w_sat;
            end
            if (r_state == S_COMMIT) begin
                r_v[r_k] <= r_vn;
                if (r_fire) begin
                    r_spike_vld <= 1'b1;
                    r_spike_id  <= r_k;
                end
            end
            if (r_state == S_SPIKE && spike_ready)
                r_spike_vld <= 1'b0;
            r_step_done <= (r_state == S_DONE);
            r_v_rd      <= r_v[v_rd_addr];
        end
    end
endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// Randomised bench for qif_neuron_scheduler against a per-timestep arithmetic model of the neurons.
module tb_qif_neuron_scheduler;
    localparam int N  = 8;
    localparam int AW = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                step_start = 1'b0;
    logic                syn_we = 1'b0;
    logic                spike_ready = 1'b0;
    logic [AW-1:0]       syn_addr = '0;
    logic [AW-1:0]       v_rd_addr = '0;
    logic signed [7:0]   syn_data = '0;
    logic                busy, step_done, spike_valid;
    logic [AW-1:0]       spike_id;
    logic signed [7:0]   v_rd_data;

    int n_vec = 0;
    int n_err = 0;
    int mv[N];
    int mi[N];
    int exp_spk[$];
    int obs_spk[$];

    qif_neuron_scheduler #(.N_NEURONS(N)) dut (
        .clk(clk), .rst_n(rst_n), .step_start(step_start), .busy(busy), .step_done(step_done),
        .syn_we(syn_we), .syn_addr(syn_addr), .syn_data(syn_data),
        .spike_valid(spike_valid), .spike_id(spike_id), .spike_ready(spike_ready),
        .v_rd_addr(v_rd_addr), .v_rd_data(v_rd_data)
    );

    always #5 clk = ~clk;

    function automatic int qif(int v, int i);
        int q, s;
        if (v >= 50) return -20;
        q = v / 8;
        s = v + q * q + i / 4;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    // Advances the model one timestep; returns the expected cycles from start to step_done.
    function automatic int model_step(int stall);
        int lat = 3 * N + 1;
        exp_spk.delete();
        for (int k = 0; k < N; k++) begin
            if (mv[k] >= 50) begin
                exp_spk.push_back(k);
                lat += 1 + ((stall > 0) ? stall : 0);
            end
            mv[k] = qif(mv[k], mi[k]);
        end
        return lat;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mv[k] = -20;
            mi[k] = 0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; step_start = 1'b0; syn_we = 1'b0; spike_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic write_syn(input int a, input int d);
        @(negedge clk);
        syn_we = 1'b1; syn_addr = AW'(a); syn_data = 8'(d);
        @(negedge clk);
        syn_we = 1'b0;
        mi[a] = d;
    endtask

    task automatic read_v(input int a, output int v);
        @(negedge clk);
        v_rd_addr = AW'(a);
        @(negedge clk);
        v = v_rd_data;
    endtask

    // stall < 0: spike_ready held high; otherwise held low for 'stall' cycles per spike.
    task automatic do_step(input int stall, input bit coll, input int coll_d, input int extra_at,
                           output int lat, output bit id_bad, output bit busy_bad);
        int n = 0;
        int wait_cnt = 0;
        bit have = 1'b0;
        logic [AW-1:0] held = '0;
        obs_spk.delete();
        lat = -1; id_bad = 1'b0; busy_bad = 1'b0;
        @(negedge clk);
        spike_ready = (stall < 0);
        step_start = 1'b1;
        if (coll) begin
            syn_we = 1'b1; syn_addr = '0; syn_data = 8'(coll_d);
        end
        @(negedge clk);
        step_start = 1'b0; syn_we = 1'b0;
        while (n < 2000) begin
            if (step_done) begin
                lat = n;
                if (busy) busy_bad = 1'b1;
                break;
            end
            if (!busy) busy_bad = 1'b1;
            step_start = (n == extra_at);
            if (spike_valid) begin
                if (!have) begin
                    have = 1'b1; held = spike_id; wait_cnt = 0;
                    if (stall < 0) obs_spk.push_back(int'(spike_id));
                end else if (spike_id !== held) begin
                    id_bad = 1'b1;
                end
                if (stall >= 0 && !spike_ready) begin
                    if (wait_cnt >= stall) begin
                        spike_ready = 1'b1;
                        obs_spk.push_back(int'(spike_id));
                    end else begin
                        wait_cnt++;
                    end
                end
            end else begin
                have = 1'b0;
                if (stall >= 0) spike_ready = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        step_start = 1'b0;
        spike_ready = 1'b0;
    endtask

    task automatic test_reset();
        int v;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (spike_valid !== 1'b0) begin n_err++; $display("FAIL reset_spike_valid got %b want 0", spike_valid); end
        n_vec++; if (step_done !== 1'b0) begin n_err++; $display("FAIL reset_step_done got %b want 0", step_done); end
        n_vec++; if (spike_id !== '0) begin n_err++; $display("FAIL reset_spike_id got %0d want 0", spike_id); end
        n_vec++; if (v_rd_data !== -8'sd20) begin n_err++; $display("FAIL reset_v_rd_data got %0d want -20", v_rd_data); end
        for (int k = 0; k < N; k++) begin
            read_v(k, v);
            n_vec++; if (v != -20) begin n_err++; $display("FAIL reset_v[%0d] got %0d want -20", k, v); end
        end
    endtask

    task automatic test_zero_step();
        int lat, exp_lat, v;
        bit idb, bb;
        exp_lat = model_step(0);
        do_step(0, 1'b0, 0, -1, lat, idb, bb);
        n_vec++; if (lat != 25 || lat != exp_lat) begin n_err++; $display("FAIL zero_latency got %0d want 25", lat); end
        n_vec++; if (obs_spk.size() != 0) begin n_err++; $display("FAIL zero_spikes got %0d want 0", obs_spk.size()); end
        n_vec++; if (bb) begin n_err++; $display("FAIL zero_busy got window-error want clean"); end
        for (int k = 0; k < N; k++) begin
            read_v(k, v);
            n_vec++; if (v != -16 || v != mv[k]) begin n_err++; $display("FAIL zero_v[%0d] got %0d want -16", k, v); end
        end
    endtask

    task automatic test_i3_backpressure();
        int traj[4] = '{15, 47, 103, -20};
        int lat, exp_lat, v, stall;
        bit idb, bb;
        apply_reset();
        write_syn(3, 127);
        for (int s = 0; s < 4; s++) begin
            stall = (s == 3) ? 10 : 0;
            exp_lat = model_step(stall);
            do_step(stall, 1'b0, 0, -1, lat, idb, bb);
            n_vec++; if (lat != exp_lat) begin n_err++; $display("FAIL i3_latency step%0d got %0d want %0d", s + 1, lat, exp_lat); end
            n_vec++; if (obs_spk.size() != exp_spk.size()) begin n_err++; $display("FAIL i3_nspikes step%0d got %0d want %0d", s + 1, obs_spk.size(), exp_spk.size()); end
            else for (int j = 0; j < exp_spk.size(); j++) begin
                n_vec++; if (obs_spk[j] != exp_spk[j]) begin n_err++; $display("FAIL i3_spike_id got %0d want %0d", obs_spk[j], exp_spk[j]); end
            end
            n_vec++; if (idb || bb) begin n_err++; $display("FAIL i3_handshake step%0d got id_bad=%0b busy_bad=%0b want 0/0", s + 1, idb, bb); end
            read_v(3, v);
            n_vec++; if (v != traj[s]) begin n_err++; $display("FAIL i3_v3 step%0d got %0d want %0d", s + 1, v, traj[s]); end
        end
        n_vec++; if (lat != 36) begin n_err++; $display("FAIL i3_stall_latency got %0d want 36", lat); end
        for (int k = 0; k < N; k++) begin
            read_v(k, v);
            n_vec++; if (v != mv[k]) begin n_err++; $display("FAIL i3_final_v[%0d] got %0d want %0d", k, v, mv[k]); end
        end
    endtask

    task automatic test_collision();
        int lat, exp_lat, v, dones, busys;
        bit idb, bb;
        apply_reset();
        exp_lat = model_step(0);
        do_step(0, 1'b1, 127, 5, lat, idb, bb);
        mi[0] = 127;
        n_vec++; if (lat != exp_lat) begin n_err++; $display("FAIL coll_latency got %0d want %0d", lat, exp_lat); end
        dones = 0; busys = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (step_done) dones++;
            if (busy) busys++;
        end
        n_vec++; if (dones != 0 || busys != 0) begin n_err++; $display("FAIL coll_single_done got extra_done=%0d busy=%0d want 0/0", dones, busys); end
        read_v(0, v);
        n_vec++; if (v != -16 || v != mv[0]) begin n_err++; $display("FAIL coll_v0_old got %0d want -16", v); end
        exp_lat = model_step(0);
        do_step(0, 1'b0, 0, -1, lat, idb, bb);
        read_v(0, v);
        n_vec++; if (v != 19 || v != mv[0]) begin n_err++; $display("FAIL coll_v0_new got %0d want 19", v); end
    endtask

    task automatic test_mid_reset();
        int lat, exp_lat, v;
        bit idb, bb;
        apply_reset();
        write_syn(2, 100);
        @(negedge clk);
        step_start = 1'b1;
        @(negedge clk);
        step_start = 1'b0;
        repeat (13) @(negedge clk);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy_async got %b want 0", busy); end
        n_vec++; if (step_done !== 1'b0 || spike_valid !== 1'b0) begin n_err++; $display("FAIL midrst_outputs got done=%b vld=%b want 0/0", step_done, spike_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < N; k++) begin
            read_v(k, v);
            n_vec++; if (v != -20) begin n_err++; $display("FAIL midrst_v[%0d] got %0d want -20", k, v); end
        end
        exp_lat = model_step(0);
        do_step(0, 1'b0, 0, -1, lat, idb, bb);
        n_vec++; if (lat != exp_lat) begin n_err++; $display("FAIL midrst_latency got %0d want %0d", lat, exp_lat); end
        for (int k = 0; k < N; k++) begin
            read_v(k, v);
            n_vec++; if (v != mv[k]) begin n_err++; $display("FAIL midrst_step_v[%0d] got %0d want %0d", k, v, mv[k]); end
        end
    endtask

    task automatic test_random();
        int lat, exp_lat, v, stall;
        bit idb, bb;
        apply_reset();
        for (int s = 0; s < 10; s++) begin
            for (int w = 0; w < 3; w++)
                write_syn($urandom_range(N - 1, 0), int'($urandom_range(255, 0)) - 128);
            stall = int'($urandom_range(4, 0)) - 1;
            exp_lat = model_step(stall);
            do_step(stall, 1'b0, 0, -1, lat, idb, bb);
            n_vec++; if (lat != exp_lat) begin n_err++; $display("FAIL rnd_latency step%0d got %0d want %0d", s, lat, exp_lat); end
            n_vec++; if (obs_spk != exp_spk) begin n_err++; $display("FAIL rnd_spikes step%0d got %p want %p", s, obs_spk, exp_spk); end
            n_vec++; if (idb || bb) begin n_err++; $display("FAIL rnd_handshake step%0d got id_bad=%0b busy_bad=%0b want 0/0", s, idb, bb); end
            for (int k = 0; k < N; k++) begin
                read_v(k, v);
                n_vec++; if (v != mv[k]) begin n_err++; $display("FAIL rnd_v[%0d] step%0d got %0d want %0d", k, s, v, mv[k]); end
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_zero_step();
        test_i3_backpressure();
        test_collision();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
